// File: rtl/biriscv_fetch_queue_if.sv
// Frontend/issue bus for the dual-issue fetch queue: two push slots in, two oldest entries out.
// Handshake: a slot transfers on a cycle where its valid and its accept are both high; valid never
// depends on accept, and slot 1 only transfers on a cycle where slot 0 transfers too.
interface biriscv_fetch_queue_if;
  logic        in0_valid_i;
  logic [31:0] in0_instr_i;
  logic [31:0] in0_pc_i;
  logic [1:0]  in0_fault_i;
  logic [7:0]  in0_info_i;
  logic        in1_valid_i;
  logic [31:0] in1_instr_i;
  logic [31:0] in1_pc_i;
  logic [1:0]  in1_fault_i;
  logic [7:0]  in1_info_i;
  logic        in0_accept_o;
  logic        in1_accept_o;
  logic        out0_valid_o;
  logic [31:0] out0_instr_o;
  logic [31:0] out0_pc_o;
  logic [1:0]  out0_fault_o;
  logic [7:0]  out0_info_o;
  logic        out1_valid_o;
  logic [31:0] out1_instr_o;
  logic [31:0] out1_pc_o;
  logic [1:0]  out1_fault_o;
  logic [7:0]  out1_info_o;
  logic        out0_accept_i;
  logic        out1_accept_i;

  modport master (
    output in0_valid_i, in0_instr_i, in0_pc_i, in0_fault_i, in0_info_i,
    output in1_valid_i, in1_instr_i, in1_pc_i, in1_fault_i, in1_info_i,
    output out0_accept_i, out1_accept_i,
    input  in0_accept_o, in1_accept_o,
    input  out0_valid_o, out0_instr_o, out0_pc_o, out0_fault_o, out0_info_o,
    input  out1_valid_o, out1_instr_o, out1_pc_o, out1_fault_o, out1_info_o
  );

  modport slave (
    input  in0_valid_i, in0_instr_i, in0_pc_i, in0_fault_i, in0_info_i,
    input  in1_valid_i, in1_instr_i, in1_pc_i, in1_fault_i, in1_info_i,
    input  out0_accept_i, out1_accept_i,
    output in0_accept_o, in1_accept_o,
    output out0_valid_o, out0_instr_o, out0_pc_o, out0_fault_o, out0_info_o,
    output out1_valid_o, out1_instr_o, out1_pc_o, out1_fault_o, out1_info_o
  );
endinterface

// File: rtl/biriscv_fetch_queue.sv
// Dual-issue instruction queue between frontend and issue, flushed on branch redirect.
// Optional occupancy high-water mark enabled by defining FETCH_QUEUE_HWM_EN.
module biriscv_fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  biriscv_fetch_queue_if.slave bus,
  output logic [DEPTH_W:0]    hwm_o,
  output logic [DEPTH_W:0]    count_o
);
  localparam int ENTRY_W = 74;
  localparam logic [DEPTH_W:0] DEPTH_M1_C = (DEPTH_W+1)'(DEPTH - 1);
  localparam logic [DEPTH_W:0] DEPTH_M2_C = (DEPTH_W+1)'(DEPTH - 2);
  localparam logic [DEPTH_W:0] TWO_C      = (DEPTH_W+1)'(2);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               push0, push1, pop0, pop1;
  logic [ENTRY_W-1:0] entry0, entry1;

  // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
  assign bus.in0_accept_o = (count_q <= DEPTH_M1_C);
  assign bus.in1_accept_o = (count_q <= DEPTH_M2_C);
  assign bus.out0_valid_o = (count_q != '0);
  assign bus.out1_valid_o = (count_q >= TWO_C);

  assign push0 = bus.in0_valid_i & bus.in0_accept_o;
  assign push1 = push0 & bus.in1_valid_i & bus.in1_accept_o;
  assign pop0  = bus.out0_valid_o & bus.out0_accept_i;
  assign pop1  = pop0 & bus.out1_valid_o & bus.out1_accept_i;

  assign rd_ptr_p1 = rd_ptr_q + DEPTH_W'(1);
  assign wr_ptr_p1 = wr_ptr_q + DEPTH_W'(1);

  assign entry0 = {bus.in0_info_i, bus.in0_fault_i, bus.in0_pc_i, bus.in0_instr_i};
  assign entry1 = {bus.in1_info_i, bus.in1_fault_i, bus.in1_pc_i, bus.in1_instr_i};

  assign {bus.out0_info_o, bus.out0_fault_o, bus.out0_pc_o, bus.out0_instr_o} = mem_q[rd_ptr_q];
  assign {bus.out1_info_o, bus.out1_fault_o, bus.out1_pc_o, bus.out1_instr_o} = mem_q[rd_ptr_p1];

  always_comb begin
    rd_ptr_d = rd_ptr_q + DEPTH_W'(pop0) + DEPTH_W'(pop1);
    wr_ptr_d = wr_ptr_q + DEPTH_W'(push0) + DEPTH_W'(push1);
    count_d  = count_q + (DEPTH_W+1)'(push0) + (DEPTH_W+1)'(push1)
                       - (DEPTH_W+1)'(pop0) - (DEPTH_W+1)'(pop1);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; out data is only meaningful when qualified by its valid.
  always_ff @(posedge clk_i) begin
    if (push0 && !flush_i) mem_q[wr_ptr_q]  <= entry0;
    if (push1 && !flush_i) mem_q[wr_ptr_p1] <= entry1;
  end

  assign count_o = count_q;

`ifdef FETCH_QUEUE_HWM_EN
  logic [DEPTH_W:0] hwm_q;

  // Survives flushes; only reset clears the peak.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q <= '0;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end
  end

  assign hwm_o = hwm_q;
`else
  assign hwm_o = '0;
`endif
endmodule
